// File: rtl/tile_bram_loader.sv
// tile_bram_loader: moves 16-bit words between a load/dump stream and BRAM port A of one array tile.
// Define LOADER_CHECKSUM_EN to add the csum output (16-bit running sum of the words moved).
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready while array_busy is low
// LOAD  | writing accepted wr_data beats into the BRAM
// DUMP  | issuing BRAM reads into the 2-entry output FIFO
// DRAIN | all reads issued; emptying the in-flight read and the FIFO
// FIN   | one-cycle done pulse, then back to IDLE
module tile_bram_loader #(
  parameter logic [7:0] ARRAY_DIM = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [7:0]  cmd_tile_i,
  input  logic [7:0]  cmd_tile_j,
  input  logic [9:0]  cmd_addr,
  input  logic [10:0] cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_data,
  output logic        external,
  output logic [7:0]  Tile_i,
  output logic [7:0]  Tile_j,
  output logic        WEA,
  output logic [9:0]  ADDRA,
  output logic [15:0] DIA,
  input  logic [15:0] DOA,
  output logic        WEB,
  output logic [9:0]  ADDRB,
  output logic [15:0] DIB,
  input  logic        array_busy,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] csum
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, DUMP, DRAIN, FIN} state_t;

  state_t      state;
  state_t      state_next;

  logic [7:0]  tile_i_q;
  logic [7:0]  tile_j_q;
  logic [9:0]  addr_q;
  logic [10:0] remain_q;
  logic        err_q;

  logic        inflight_q;
  logic [15:0] fifo_mem [2];
  logic        fifo_wr_ptr;
  logic        fifo_rd_ptr;
  logic [1:0]  fifo_cnt;

  logic        accept;
  logic        tile_bad;
  logic        beat;
  logic        issue;
  logic        push;
  logic        pop;
  logic        last_word;

  // Handshakes are gated by reset so nothing moves in the cycle reset is sampled.
  assign cmd_ready = (state == IDLE) && !array_busy && !reset;
  assign wr_ready  = (state == LOAD) && !reset;

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    tile_bad  = (cmd_tile_i >= ARRAY_DIM) || (cmd_tile_j >= ARRAY_DIM);
    beat      = wr_valid && wr_ready;
    // One read outstanding at most per free FIFO slot, counting the read already in flight.
    issue     = (state == DUMP) && (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < 3'd2);
    push      = inflight_q;
    pop       = (fifo_cnt != 2'd0) && rd_ready;
    last_word = (remain_q == 11'd1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !tile_bad) begin
          if (cmd_len == 11'd0) state_next = FIN;
          else if (cmd_dir)     state_next = DUMP;
          else                  state_next = LOAD;
        end
      end
      LOAD:    if (beat && last_word) state_next = FIN;
      DUMP:    if (issue && last_word) state_next = DRAIN;
      DRAIN:   if ((fifo_cnt == 2'd0) && !inflight_q) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tile_i_q    <= 8'd0;
      tile_j_q    <= 8'd0;
      addr_q      <= 10'd0;
      remain_q    <= 11'd0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      state      <= state_next;
      err_q      <= accept && tile_bad;
      inflight_q <= issue;

      if (accept && !tile_bad) begin
        tile_i_q <= cmd_tile_i;
        tile_j_q <= cmd_tile_j;
        addr_q   <= cmd_addr;
        remain_q <= cmd_len;
      end else if (beat || issue) begin
        addr_q   <= addr_q + 10'd1;
        remain_q <= remain_q - 11'd1;
      end

      if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_ptr] <= DOA;
  end

  assign rd_valid = (fifo_cnt != 2'd0);
  assign rd_data  = rd_valid ? fifo_mem[fifo_rd_ptr] : 16'h0000;

  assign external = (state == LOAD) || (state == DUMP) || (state == DRAIN);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);
  assign err      = err_q;
  assign Tile_i   = tile_i_q;
  assign Tile_j   = tile_j_q;

  assign WEA   = beat;
  assign ADDRA = addr_q;
  assign DIA   = beat ? wr_data : 16'h0000;

  assign WEB   = 1'b0;
  assign ADDRB = 10'd0;
  assign DIB   = 16'h0000;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset)       csum_q <= 16'h0000;
    else if (accept) csum_q <= 16'h0000;
    else if (beat)   csum_q <= csum_q + wr_data;
    else if (pop)    csum_q <= csum_q + rd_data;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_tile_bram_loader.sv
// Directed bench for tile_bram_loader with a synchronous-read BRAM model on port A.
// Exercises load/dump round trip with wrap, backpressure, bad tile, array_busy, mid-load reset, len=0.
module tb_tile_bram_loader;

  localparam logic [7:0] DIM = 8'h04;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [7:0]  cmd_tile_i;
  logic [7:0]  cmd_tile_j;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        external;
  logic [7:0]  Tile_i;
  logic [7:0]  Tile_j;
  logic        WEA;
  logic [9:0]  ADDRA;
  logic [15:0] DIA;
  logic [15:0] DOA;
  logic        WEB;
  logic [9:0]  ADDRB;
  logic [15:0] DIB;
  logic        array_busy;
  logic        busy;
  logic        done;
  logic        err;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  tile_bram_loader #(.ARRAY_DIM(DIM)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_tile_i(cmd_tile_i), .cmd_tile_j(cmd_tile_j), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .external(external), .Tile_i(Tile_i), .Tile_j(Tile_j),
    .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(DOA),
    .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB),
    .array_busy(array_busy), .busy(busy), .done(done), .err(err)
`ifdef LOADER_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  // BRAM port A: write-enable store, registered read one cycle after ADDRA.
  logic [15:0] bram [1024];
  always @(posedge clk) begin
    if (WEA) bram[ADDRA] <= DIA;
    DOA <= bram[ADDRA];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observation log, sampled on the falling edge.
  logic [9:0]  wea_addr [$];
  logic [15:0] wea_data [$];
  logic [15:0] rd_log   [$];
  int done_cnt, err_cnt, ext_cnt, rdv_cnt;

  always @(negedge clk) begin
    if (WEA) begin
      wea_addr.push_back(ADDRA);
      wea_data.push_back(DIA);
    end
    if (rd_valid && rd_ready) rd_log.push_back(rd_data);
    if (done)     done_cnt++;
    if (err)      err_cnt++;
    if (external) ext_cnt++;
    if (rd_valid) rdv_cnt++;
  end

  task automatic clear_log();
    wea_addr.delete();
    wea_data.delete();
    rd_log.delete();
    done_cnt = 0;
    err_cnt  = 0;
    ext_cnt  = 0;
    rdv_cnt  = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic dir, input logic [7:0] ti, input logic [7:0] tj,
                          input logic [9:0] addr, input logic [10:0] len);
    int w;
    cmd_dir    = dir;
    cmd_tile_i = ti;
    cmd_tile_j = tj;
    cmd_addr   = addr;
    cmd_len    = len;
    cmd_valid  = 1'b1;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_accept_wait", 32'(w < 20), 32'h1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [9:0]  exp_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
  logic [15:0] exp_data [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
  logic        ld_valid [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] ld_data  [5] = '{16'h0001, 16'h0002, 16'h0000, 16'h0003, 16'h0004};
  logic [3:0]  rd_pat = 4'b1001;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_tile_i = 8'd0; cmd_tile_j = 8'd0;
    cmd_addr = 10'd0; cmd_len = 11'd0; wr_valid = 1'b0; wr_data = 16'h0;
    rd_ready = 1'b0; array_busy = 1'b0;
    clear_log();
    tick();
    tick();

    // Reset values while reset is held
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_wr_ready",  32'(wr_ready),  32'h0);
    chk("rst_rd_valid",  32'(rd_valid),  32'h0);
    chk("rst_rd_data",   32'(rd_data),   32'h0);
    chk("rst_external",  32'(external),  32'h0);
    chk("rst_tile_i",    32'(Tile_i),    32'h0);
    chk("rst_tile_j",    32'(Tile_j),    32'h0);
    chk("rst_wea",       32'(WEA),       32'h0);
    chk("rst_addra",     32'(ADDRA),     32'h0);
    chk("rst_dia",       32'(DIA),       32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_done",      32'(done),      32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_tied_b",    {15'h0, WEB, ADDRB, DIB}, 32'h0);
    reset = 1'b0;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    // Load tile(0,0) at 0x3FE, 4 words, with one idle cycle between words 2 and 3
    clear_log();
    send_cmd(1'b0, 8'd0, 8'd0, 10'h3FE, 11'd4);
    chk("load_busy",     32'(busy),     32'h1);
    chk("load_external", 32'(external), 32'h1);
    chk("load_wr_ready", 32'(wr_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      wr_valid = ld_valid[k];
      wr_data  = ld_data[k];
      tick();
    end
    wr_valid = 1'b0;
    chk("load_done", 32'(done), 32'h1);
`ifdef LOADER_CHECKSUM_EN
    chk("load_csum", 32'(csum), 32'h000A);
`endif
    tick();
    chk("load_done_end", 32'(done), 32'h0);
    chk("load_busy_end", 32'(busy), 32'h0);
    chk("load_wea_n", 32'(wea_addr.size()), 32'h4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("load_addr%0d", i), 32'((i < wea_addr.size()) ? wea_addr[i] : 10'h2AA), 32'(exp_addr[i]));
      chk($sformatf("load_data%0d", i), 32'((i < wea_data.size()) ? wea_data[i] : 16'hBEEF), 32'(exp_data[i]));
    end
    chk("load_done_n", 32'(done_cnt), 32'h1);

    // Dump same range with rd_ready pattern 1,0,0,1 repeating
    clear_log();
    send_cmd(1'b1, 8'd0, 8'd0, 10'h3FE, 11'd4);
    chk("dump_external", 32'(external), 32'h1);
    begin
      int w;
      w = 0;
      while (!done && w < 80) begin
        rd_ready = rd_pat[w % 4];
        tick();
        w++;
      end
      chk("dump_done_wait", 32'(w < 80), 32'h1);
    end
    rd_ready = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk("dump_csum", 32'(csum), 32'h000A);
`endif
    tick();
    chk("dump_rd_n", 32'(rd_log.size()), 32'h4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("dump_data%0d", i), 32'((i < rd_log.size()) ? rd_log[i] : 16'hBEEF), 32'(exp_data[i]));
    chk("dump_done_n", 32'(done_cnt), 32'h1);
    chk("dump_no_wea", 32'(wea_addr.size()), 32'h0);
    chk("dump_rd_valid_end", 32'(rd_valid), 32'h0);

    // Out-of-range tile: error pulse only
    clear_log();
    wr_valid = 1'b1;
    wr_data  = 16'h7777;
    send_cmd(1'b0, DIM, 8'd0, 10'h020, 11'd4);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_busy", 32'(busy), 32'h0);
    tick();
    chk("bad_err_end", 32'(err), 32'h0);
    tick();
    tick();
    wr_valid = 1'b0;
    chk("bad_err_n", 32'(err_cnt), 32'h1);
    chk("bad_ext_n", 32'(ext_cnt), 32'h0);
    chk("bad_wea_n", 32'(wea_addr.size()), 32'h0);
    chk("bad_done_n", 32'(done_cnt), 32'h0);

    // cmd_valid held while array_busy; accepted right after it falls; later array_busy ignored
    clear_log();
    array_busy = 1'b1;
    cmd_dir = 1'b0; cmd_tile_i = 8'd3; cmd_tile_j = 8'd2; cmd_addr = 10'h010; cmd_len = 11'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("abusy_ready%0d", i), 32'(cmd_ready), 32'h0);
    end
    tick();
    array_busy = 1'b0;
    @(negedge clk);
    chk("abusy_ready_fall", 32'(cmd_ready), 32'h1);
    tick();
    cmd_valid = 1'b0;
    array_busy = 1'b1;
    chk("abusy_busy", 32'(busy), 32'h1);
    chk("abusy_tile", {16'h0, Tile_i, Tile_j}, 32'h0302);
    wr_valid = 1'b1;
    wr_data  = 16'h55AA;
    tick();
    wr_valid = 1'b0;
    chk("abusy_done", 32'(done), 32'h1);
    tick();
    array_busy = 1'b0;
    chk("abusy_wea_n", 32'(wea_addr.size()), 32'h1);
    chk("abusy_wea", {(wea_addr.size() > 0) ? wea_addr[0] : 10'h3FF, (wea_data.size() > 0) ? wea_data[0] : 16'h0},
        {6'h0, 10'h010, 16'h55AA});

    // Reset after the 2nd of 4 load words
    clear_log();
    send_cmd(1'b0, 8'd0, 8'd0, 10'h100, 11'd4);
    wr_valid = 1'b1;
    wr_data  = 16'h0011;
    tick();
    wr_data  = 16'h0022;
    tick();
    wr_data  = 16'h0033;
    reset    = 1'b1;
    tick();
    chk("rstmid_external", 32'(external), 32'h0);
    chk("rstmid_wea",      32'(WEA),      32'h0);
    chk("rstmid_busy",     32'(busy),     32'h0);
    reset    = 1'b0;
    wr_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_wea_n",  32'(wea_addr.size()), 32'h2);
    chk("rstmid_done_n", 32'(done_cnt), 32'h0);

    // Zero-length dump
    clear_log();
    send_cmd(1'b1, 8'd0, 8'd0, 10'h005, 11'd0);
    chk("len0_done", 32'(done), 32'h1);
    tick();
    chk("len0_done_end", 32'(done), 32'h0);
    tick();
    chk("len0_done_n", 32'(done_cnt), 32'h1);
    chk("len0_wea_n",  32'(wea_addr.size()), 32'h0);
    chk("len0_rdv_n",  32'(rdv_cnt), 32'h0);
    chk("len0_ext_n",  32'(ext_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_bram_loader.md
TILE_BRAM_LOADER -- requirements
Module: tile_bram_loader

Interface
REQ-001 SHALL have parameter ARRAY_DIM, default 8'h01, meaning tiles per array row/column.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_dir in 1 (0 load, 1 dump); cmd_tile_i in 8; cmd_tile_j in 8; cmd_addr in 10, start word; cmd_len in 11, word count 0..1024.
REQ-004 SHALL have ports: wr_valid in 1; wr_ready out 1; wr_data in 16, the load stream.
REQ-005 SHALL have ports: rd_valid out 1; rd_ready in 1; rd_data out 16, the dump stream.
REQ-006 SHALL have array-side ports: external out 1; Tile_i out 8; Tile_j out 8; WEA out 1; ADDRA out 10; DIA out 16; DOA in 16; WEB out 1, tied 0; ADDRB out 10, tied 0; DIB out 16, tied 0.
REQ-007 SHALL have ports: array_busy in 1, array controller running; busy out 1; done out 1, one-cycle pulse; err out 1, one-cycle pulse.

Function
REQ-008 SHALL implement states IDLE, LOAD, DUMP, DRAIN, FIN.
REQ-009 cmd_ready SHALL be 1 only in IDLE with array_busy=0; a command is accepted on cmd_valid&cmd_ready.
REQ-010 On acceptance, tile, address and length SHALL be registered; Tile_i/Tile_j SHALL hold these values until the return to IDLE.
REQ-011 cmd_tile_i or cmd_tile_j >= ARRAY_DIM SHALL give err=1 for one cycle, no BRAM access, and a return to IDLE.
REQ-012 cmd_len=0 SHALL go to FIN directly, with no BRAM access.
REQ-013 external SHALL be 1 in LOAD, DUMP and DRAIN, and 0 in IDLE and FIN.
REQ-014 In LOAD: wr_ready=1; each wr_valid&wr_ready beat SHALL drive WEA=1, DIA=wr_data and ADDRA=current address in the same cycle; WEA=0 in every other cycle.
REQ-015 Address SHALL increment by 1 per word, modulo 1024 (1023 wraps to 0).
REQ-016 After the last loaded word, the block SHALL go to FIN.
REQ-017 In DUMP: ADDRA SHALL issue one read per cycle with WEA=0; DOA is valid one cycle after ADDRA.
REQ-018 Dump data SHALL pass through a 2-entry FIFO; a read SHALL issue only if FIFO occupancy plus in-flight reads < 2, so no word is lost or duplicated under rd_ready backpressure.
REQ-019 rd_valid SHALL equal FIFO non-empty; rd_data SHALL be the FIFO head; words SHALL be delivered in address order.
REQ-020 After the last read is issued, the block SHALL go to DRAIN, and from DRAIN to FIN once the FIFO is empty and no read is in flight.
REQ-021 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 Changes to array_busy after acceptance SHALL be ignored until IDLE.

Reset
REQ-024 On reset the state SHALL go to IDLE and the FIFO and in-flight count SHALL clear; at the next edge, cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, external=0, Tile_i=0, Tile_j=0, WEA=0, ADDRA=0, DIA=0, busy=0, done=0, err=0.
REQ-025 Reset mid-transfer SHALL abort with no further WEA pulse, and SHALL not produce done.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN, when defined, SHALL add output csum (16 bits): the modulo-2^16 sum of all words written (LOAD) or delivered (DUMP) by the current command, cleared on acceptance and valid while done=1.
REQ-027 Without LOADER_CHECKSUM_EN, the csum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 The bench SHALL cover: load tile(0,0), addr 0x3FE, len 4, data 1,2,3,4 -> WEA pulses at ADDRA 0x3FE, 0x3FF, 0x000, 0x001, then done; with LOADER_CHECKSUM_EN, csum=0x000A.
REQ-029 The bench SHALL cover: dump same range with rd_ready toggled 1,0,0,1,... -> rd_data 1,2,3,4 exactly once each in order, then done.
REQ-030 The bench SHALL cover: cmd_tile_i=ARRAY_DIM -> err pulse, external stays 0, no WEA, no done.
REQ-031 The bench SHALL cover: cmd_valid held with array_busy=1 for 5 cycles -> cmd_ready=0 throughout; accepted in the cycle after array_busy falls.
REQ-032 The bench SHALL cover: reset asserted after the 2nd of 4 load words -> next cycle external=0, WEA=0, busy=0, and no done pulse.
REQ-033 The bench SHALL cover: cmd_len=0 -> done one cycle after acceptance, no WEA and no rd_valid.
